// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX FIFO write port and the parity-type
// setting among NUM_REQ byte-stream requesters. Grants are round-robin and
// burst-atomic. A parity change waits until the transmit path has drained.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]        i_req_last,
    input  logic [NUM_REQ*2-1:0]      i_req_parity,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic                      i_full,
    input  logic                      i_tx_idle,
    output logic                      o_wr_en,
    output logic [DATA_W-1:0]         o_data_out,
    output logic [1:0]                o_parity_type,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic                      o_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        XFER
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   widx_q, widx_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         want_par_q, want_par_d;
    logic [1:0]         par_q, par_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   scan_idx;
    logic [1:0]         win_par;
    logic               sel_valid;
    logic               sel_last;
    logic [DATA_W-1:0]  sel_data;
    logic               fire;

    // Round-robin winner: first valid requester at or above the pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = IDX_W'((32'(rr_q) + i) % NUM_REQ);
            if (!win_found && i_req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Lane muxes: parity of the prospective winner, and the granted requester's byte stream.
    always_comb begin
        win_par   = 2'b00;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (win_idx == IDX_W'(k)) begin
                win_par = i_req_parity[2*k +: 2];
            end
            if (widx_q == IDX_W'(k)) begin
                sel_valid = i_req_valid[k];
                sel_last  = i_req_last[k];
                sel_data  = i_req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and output decode for the IDLE/DRAIN/XFER arbiter FSM.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        widx_d      = widx_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        want_par_d  = want_par_q;
        par_d       = par_q;
        o_req_ready = '0;
        o_wr_en     = 1'b0;
        o_busy      = 1'b0;
        fire        = 1'b0;
        o_data_out  = sel_data;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    widx_d           = win_idx;
                    cnt_d            = '0;
                    want_par_d       = win_par;
                    state_d          = (win_par == par_q) ? XFER : DRAIN;
                end
            end
            DRAIN: begin
                o_busy = 1'b1;
                if (i_tx_idle) begin
                    par_d   = want_par_q;
                    state_d = XFER;
                end
            end
            XFER: begin
                o_busy              = 1'b1;
                o_req_ready[widx_q] = !i_full;
                fire                = sel_valid && !i_full;
                o_wr_en             = fire;
                if (fire) begin
                    cnt_d = cnt_q + 1'b1;
                    // Limit compare uses the pre-increment count, so last and limit on the same byte release once.
                    if (sel_last || (cnt_q == CNT_W'(MAX_BURST - 1))) begin
                        state_d = IDLE;
                        grant_d = '0;
                        rr_d    = (widx_q == IDX_W'(NUM_REQ - 1)) ? '0 : widx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State register; reset abandons any burst in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            widx_q     <= '0;
            rr_q       <= '0;
            cnt_q      <= '0;
            want_par_q <= 2'b00;
            par_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            widx_q     <= widx_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            want_par_q <= want_par_d;
            par_q      <= par_d;
        end
    end

    assign o_grant       = grant_q;
    assign o_parity_type = par_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, DATA_W=8, MAX_BURST=4).
// Per-requester byte queues feed the DUT; every cycle's outputs are logged
// and each scenario task compares its slice of the log with hand-built tables.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  i_req_valid  = '0;
    logic [31:0] i_req_data   = '0;
    logic [3:0]  i_req_last   = '0;
    logic [7:0]  i_req_parity = '0;
    logic [3:0]  o_req_ready;
    logic        i_full;
    logic        i_tx_idle;
    logic        o_wr_en;
    logic [7:0]  o_data_out;
    logic [1:0]  o_parity_type;
    logic [3:0]  o_grant;
    logic        o_busy;

    uart_tx_arbiter #(
        .NUM_REQ  (4),
        .DATA_W   (8),
        .MAX_BURST(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (i_req_valid),
        .i_req_data   (i_req_data),
        .i_req_last   (i_req_last),
        .i_req_parity (i_req_parity),
        .o_req_ready  (o_req_ready),
        .i_full       (i_full),
        .i_tx_idle    (i_tx_idle),
        .o_wr_en      (o_wr_en),
        .o_data_out   (o_data_out),
        .o_parity_type(o_parity_type),
        .o_grant      (o_grant),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] grant;
        logic       wr;
        logic [7:0] data;
        logic [3:0] ready;
        logic [1:0] par;
        logic       busy;
        logic       full;
    } tr_t;

    tr_t         tr[$];
    logic [8:0]  mem[4][32];
    int unsigned head[4];
    int unsigned tail[4];
    logic [1:0]  par[4];
    int          n_tests = 0;
    int          n_fail  = 0;

    tr_t         rec;
    logic [3:0]  fire_v;

    // Requester model: log outputs just before the edge, pop accepted bytes after it.
    always begin
        @(negedge clk);
        #4;
        rec.grant = o_grant;
        rec.wr    = o_wr_en;
        rec.data  = o_data_out;
        rec.ready = o_req_ready;
        rec.par   = o_parity_type;
        rec.busy  = o_busy;
        rec.full  = i_full;
        tr.push_back(rec);
        fire_v = o_req_ready & i_req_valid;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (!rst_n) head[k] = tail[k];
            else if (fire_v[k]) head[k] = head[k] + 1;
            if (head[k] < tail[k]) begin
                i_req_valid[k]       = 1'b1;
                i_req_data[k*8 +: 8] = mem[k][head[k]][7:0];
                i_req_last[k]        = mem[k][head[k]][8];
            end else begin
                i_req_valid[k]       = 1'b0;
                i_req_data[k*8 +: 8] = 8'h00;
                i_req_last[k]        = 1'b0;
            end
            i_req_parity[2*k +: 2] = par[k];
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        mem[k][tail[k]] = {l, d};
        tail[k] = tail[k] + 1;
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if (o_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", o_grant); end
        n_tests++; if (o_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", o_wr_en); end
        n_tests++; if (o_req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", o_req_ready); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        n_tests++; if (o_parity_type !== 2'b00) begin n_fail++; $display("FAIL reset_parity: got %b expected 00", o_parity_type); end
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_burst();
        int base;
        logic [3:0] eg[5];
        logic       ew[5];
        logic [7:0] ed[5];
        // Completed burst from req1 moves the pointer to 2.
        par[1] = 2'b00;
        push(1, 8'h70, 1'b1);
        step();
        base = tr.size();
        repeat (3) step();
        n_tests++; if (tr[base+1].grant !== 4'b0010 || tr[base+1].wr !== 1'b1 || tr[base+1].data !== 8'h70)
            begin n_fail++; $display("FAIL rmb_first: got g=%b wr=%b d=%h expected g=0010 wr=1 d=70", tr[base+1].grant, tr[base+1].wr, tr[base+1].data); end
        // Second burst switches parity, then reset lands mid-burst.
        par[1] = 2'b01;
        push(1, 8'h71, 1'b0);
        push(1, 8'h72, 1'b0);
        step();
        base = tr.size();
        repeat (3) step();
        n_tests++; if (tr[base+1].busy !== 1'b1 || tr[base+1].wr !== 1'b0 || tr[base+1].par !== 2'b00)
            begin n_fail++; $display("FAIL rmb_drain: got busy=%b wr=%b par=%b expected busy=1 wr=0 par=00", tr[base+1].busy, tr[base+1].wr, tr[base+1].par); end
        n_tests++; if (tr[base+2].wr !== 1'b1 || tr[base+2].data !== 8'h71 || tr[base+2].par !== 2'b01)
            begin n_fail++; $display("FAIL rmb_xfer: got wr=%b d=%h par=%b expected wr=1 d=71 par=01", tr[base+2].wr, tr[base+2].data, tr[base+2].par); end
        n_tests++; if (o_wr_en !== 1'b1) begin n_fail++; $display("FAIL rmb_pre_reset_wr: got %b expected 1", o_wr_en); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (o_grant !== 4'b0000) begin n_fail++; $display("FAIL rmb_grant: got %b expected 0000", o_grant); end
        n_tests++; if (o_wr_en !== 1'b0) begin n_fail++; $display("FAIL rmb_wr_en: got %b expected 0", o_wr_en); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rmb_busy: got %b expected 0", o_busy); end
        n_tests++; if (o_req_ready !== 4'b0000) begin n_fail++; $display("FAIL rmb_ready: got %b expected 0000", o_req_ready); end
        n_tests++; if (o_parity_type !== 2'b00) begin n_fail++; $display("FAIL rmb_parity: got %b expected 00", o_parity_type); end
        repeat (2) step();
        rst_n = 1'b1;
        // Pointer back at 0: req1 must win over req3.
        par[1] = 2'b00;
        par[3] = 2'b00;
        push(1, 8'h80, 1'b1);
        push(3, 8'h90, 1'b1);
        step();
        base = tr.size();
        repeat (5) step();
        eg = '{4'h0, 4'h2, 4'h0, 4'h8, 4'h0};
        ew = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ed = '{8'h00, 8'h80, 8'h00, 8'h90, 8'h00};
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (tr[base+i].grant !== eg[i]) begin n_fail++; $display("FAIL rmb_after_grant[%0d]: got %b expected %b", i, tr[base+i].grant, eg[i]); end
            n_tests++; if (tr[base+i].wr !== ew[i]) begin n_fail++; $display("FAIL rmb_after_wr[%0d]: got %b expected %b", i, tr[base+i].wr, ew[i]); end
            if (ew[i]) begin
                n_tests++; if (tr[base+i].data !== ed[i]) begin n_fail++; $display("FAIL rmb_after_data[%0d]: got %h expected %h", i, tr[base+i].data, ed[i]); end
            end
        end
    endtask

    task automatic test_round_robin();
        int base;
        logic [3:0] eg[9];
        logic       ew[9];
        logic [7:0] ed[9];
        par[0] = 2'b00;
        par[2] = 2'b00;
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b1);
        push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b1);
        step();
        base = tr.size();
        repeat (9) step();
        eg = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0};
        ew = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        ed = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'h00, 8'hC0, 8'hC1, 8'hC2, 8'h00};
        for (int i = 0; i < 9; i++) begin
            n_tests++; if (tr[base+i].grant !== eg[i]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, tr[base+i].grant, eg[i]); end
            n_tests++; if (tr[base+i].wr !== ew[i]) begin n_fail++; $display("FAIL rr_wr[%0d]: got %b expected %b", i, tr[base+i].wr, ew[i]); end
            if (ew[i]) begin
                n_tests++; if (tr[base+i].data !== ed[i]) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", i, tr[base+i].data, ed[i]); end
            end
        end
    endtask

    task automatic test_parity_switch();
        int base;
        i_tx_idle = 1'b0;
        par[1] = 2'b01;
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b1);
        step();
        base = tr.size();
        repeat (21) step();
        n_tests++; if (tr[base].grant !== 4'b0000) begin n_fail++; $display("FAIL ps_idle_grant: got %b expected 0000", tr[base].grant); end
        for (int i = 1; i <= 20; i++) begin
            n_tests++;
            if (tr[base+i].grant !== 4'b0010 || tr[base+i].busy !== 1'b1 || tr[base+i].wr !== 1'b0 ||
                tr[base+i].ready !== 4'b0000 || tr[base+i].par !== 2'b00) begin
                n_fail++;
                $display("FAIL ps_drain[%0d]: got g=%b busy=%b wr=%b rdy=%b par=%b expected g=0010 busy=1 wr=0 rdy=0000 par=00",
                         i, tr[base+i].grant, tr[base+i].busy, tr[base+i].wr, tr[base+i].ready, tr[base+i].par);
            end
        end
        i_tx_idle = 1'b1;
        repeat (4) step();
        n_tests++; if (tr[base+21].par !== 2'b00 || tr[base+21].wr !== 1'b0) begin n_fail++; $display("FAIL ps_idle_edge: got par=%b wr=%b expected par=00 wr=0", tr[base+21].par, tr[base+21].wr); end
        n_tests++; if (tr[base+22].par !== 2'b01) begin n_fail++; $display("FAIL ps_parity: got %b expected 01", tr[base+22].par); end
        n_tests++; if (tr[base+22].wr !== 1'b1 || tr[base+22].data !== 8'h11) begin n_fail++; $display("FAIL ps_byte0: got wr=%b d=%h expected wr=1 d=11", tr[base+22].wr, tr[base+22].data); end
        n_tests++; if (tr[base+23].wr !== 1'b1 || tr[base+23].data !== 8'h12) begin n_fail++; $display("FAIL ps_byte1: got wr=%b d=%h expected wr=1 d=12", tr[base+23].wr, tr[base+23].data); end
        n_tests++; if (tr[base+24].grant !== 4'b0000 || tr[base+24].par !== 2'b01) begin n_fail++; $display("FAIL ps_release: got g=%b par=%b expected g=0000 par=01", tr[base+24].grant, tr[base+24].par); end
    endtask

    task automatic test_backpressure();
        int base;
        int writes;
        par[2] = 2'b01;
        push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1);
        step();
        base = tr.size();
        repeat (2) step();
        i_full = 1'b1;
        repeat (5) step();
        i_full = 1'b0;
        repeat (3) step();
        n_tests++; if (tr[base+1].wr !== 1'b1 || tr[base+1].data !== 8'h20) begin n_fail++; $display("FAIL bp_byte0: got wr=%b d=%h expected wr=1 d=20", tr[base+1].wr, tr[base+1].data); end
        for (int i = 2; i <= 6; i++) begin
            n_tests++;
            if (tr[base+i].wr !== 1'b0 || tr[base+i].ready !== 4'b0000 || tr[base+i].grant !== 4'b0100) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: got wr=%b rdy=%b g=%b expected wr=0 rdy=0000 g=0100", i, tr[base+i].wr, tr[base+i].ready, tr[base+i].grant);
            end
        end
        n_tests++; if (tr[base+7].wr !== 1'b1 || tr[base+7].data !== 8'h21) begin n_fail++; $display("FAIL bp_byte1: got wr=%b d=%h expected wr=1 d=21", tr[base+7].wr, tr[base+7].data); end
        n_tests++; if (tr[base+8].wr !== 1'b1 || tr[base+8].data !== 8'h22) begin n_fail++; $display("FAIL bp_byte2: got wr=%b d=%h expected wr=1 d=22", tr[base+8].wr, tr[base+8].data); end
        n_tests++; if (tr[base+9].grant !== 4'b0000) begin n_fail++; $display("FAIL bp_release: got %b expected 0000", tr[base+9].grant); end
        writes = 0;
        for (int i = 0; i <= 9; i++) begin
            if (tr[base+i].wr === 1'b1) writes++;
            n_tests++; if (tr[base+i].wr === 1'b1 && tr[base+i].full !== 1'b0) begin n_fail++; $display("FAIL bp_wr_while_full[%0d]: got full=%b expected 0", i, tr[base+i].full); end
            n_tests++; if (tr[base+i].wr === 1'b1 && $countones(tr[base+i].ready) != 1) begin n_fail++; $display("FAIL bp_ready_onehot[%0d]: got %b expected one bit", i, tr[base+i].ready); end
        end
        n_tests++; if (writes != 3) begin n_fail++; $display("FAIL bp_write_count: got %0d expected 3", writes); end
    endtask

    task automatic test_forced_rotation();
        int base;
        logic [3:0] eg[20];
        logic       ew[20];
        logic [7:0] ed[20];
        par[3] = 2'b01;
        par[0] = 2'b01;
        for (int b = 0; b < 10; b++) push(3, 8'h30 + 8'(b), 1'b0);
        push(0, 8'h40, 1'b0);
        push(0, 8'h41, 1'b1);
        step();
        base = tr.size();
        repeat (17) step();
        // req3 has run dry with its grant held; one closing byte ends the burst.
        push(3, 8'h3A, 1'b1);
        repeat (3) step();
        eg = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h0, 4'h8,
               4'h8, 4'h8, 4'h8, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0};
        ew = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
               1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        ed = '{8'h00, 8'h30, 8'h31, 8'h32, 8'h33, 8'h00, 8'h40, 8'h41, 8'h00, 8'h34,
               8'h35, 8'h36, 8'h37, 8'h00, 8'h38, 8'h39, 8'h00, 8'h00, 8'h3A, 8'h00};
        for (int i = 0; i < 20; i++) begin
            n_tests++; if (tr[base+i].grant !== eg[i]) begin n_fail++; $display("FAIL fr_grant[%0d]: got %b expected %b", i, tr[base+i].grant, eg[i]); end
            n_tests++; if (tr[base+i].wr !== ew[i]) begin n_fail++; $display("FAIL fr_wr[%0d]: got %b expected %b", i, tr[base+i].wr, ew[i]); end
            if (ew[i]) begin
                n_tests++; if (tr[base+i].data !== ed[i]) begin n_fail++; $display("FAIL fr_data[%0d]: got %h expected %h", i, tr[base+i].data, ed[i]); end
            end
            n_tests++; if (tr[base+i].par !== 2'b01) begin n_fail++; $display("FAIL fr_parity[%0d]: got %b expected 01", i, tr[base+i].par); end
        end
    endtask

    task automatic test_last_at_limit();
        int base;
        logic [3:0] eg[9];
        logic       ew[9];
        logic [7:0] ed[9];
        par[0] = 2'b01;
        par[1] = 2'b01;
        push(0, 8'h50, 1'b0); push(0, 8'h51, 1'b0); push(0, 8'h52, 1'b0); push(0, 8'h53, 1'b1);
        push(1, 8'h60, 1'b1);
        step();
        base = tr.size();
        repeat (9) step();
        eg = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h0, 4'h0};
        ew = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        ed = '{8'h00, 8'h50, 8'h51, 8'h52, 8'h53, 8'h00, 8'h60, 8'h00, 8'h00};
        for (int i = 0; i < 9; i++) begin
            n_tests++; if (tr[base+i].grant !== eg[i]) begin n_fail++; $display("FAIL ll_grant[%0d]: got %b expected %b", i, tr[base+i].grant, eg[i]); end
            n_tests++; if (tr[base+i].wr !== ew[i]) begin n_fail++; $display("FAIL ll_wr[%0d]: got %b expected %b", i, tr[base+i].wr, ew[i]); end
            if (ew[i]) begin
                n_tests++; if (tr[base+i].data !== ed[i]) begin n_fail++; $display("FAIL ll_data[%0d]: got %h expected %h", i, tr[base+i].data, ed[i]); end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        i_full    = 1'b0;
        i_tx_idle = 1'b1;
        for (int k = 0; k < 4; k++) begin
            par[k]  = 2'b00;
            tail[k] = 0;
        end
        test_reset();
        test_reset_mid_burst();
        test_round_robin();
        test_parity_switch();
        test_backpressure();
        test_forced_rotation();
        test_last_at_limit();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit path (TX FIFO write port plus parity-type configuration) among NUM_REQ byte-stream requesters.
- Round-robin arbitration with burst-atomic grants: a granted requester keeps the port until it flags the last byte or hits MAX_BURST bytes.
- Parity type is per-requester. It may only change while the transmit path is fully drained, so queued bytes never go out with the wrong parity.
- Sits between requester logic and the UART top's i_wr_en/i_data_in/i_parity_type/i_full inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
MAX_BURST, 16, max bytes per grant before forced rotation (2..256)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_req_valid  input  NUM_REQ  per-requester byte valid
i_req_data  input  NUM_REQ*DATA_W  per-requester byte; requester k at bits [k*DATA_W +: DATA_W]
i_req_last  input  NUM_REQ  marks final byte of a burst
i_req_parity  input  NUM_REQ*2  per-requester parity type (00 none, 01 odd, 10 even)
o_req_ready  output  NUM_REQ  per-requester accept
i_full  input  1  TX FIFO full
i_tx_idle  input  1  TX FIFO empty and transmitter in IDLE state
o_wr_en  output  1  TX FIFO write strobe
o_data_out  output  DATA_W  byte to TX FIFO
o_parity_type  output  2  parity type driven to the UART
o_grant  output  NUM_REQ  one-hot current grant, 0 when none
o_busy  output  1  high in DRAIN or XFER

Behaviour:
- Reset, asynchronous: state IDLE, o_grant=0, o_parity_type=2'b00, rr pointer=0, burst count=0, parity latch=0.
- Reset forces o_wr_en=0, o_req_ready=0, o_busy=0. o_data_out is don't-care, but the bench checks it only when o_wr_en=1.
- Reset mid-burst abandons the burst; no partial state survives.
- States: IDLE, DRAIN, XFER (registered).
- IDLE:
  - If any i_req_valid, pick winner w = first set bit scanning upward from the rr pointer, with wrap-around.
  - Register o_grant=onehot(w), burst count=0, and latch want_par = i_req_parity[w].
  - If want_par == o_parity_type, go to XFER. Otherwise go to DRAIN.
  - If no request, stay in IDLE.
  - Latency: valid in cycle N gives ready at the earliest in cycle N+1.
- DRAIN:
  - o_req_ready=0.
  - When i_tx_idle=1, the next edge sets o_parity_type=want_par and the state goes to XFER.
  - No timeout.
- XFER:
  - o_req_ready[w] = !i_full. Other ready bits are 0.
  - fire = i_req_valid[w] & o_req_ready[w].
  - o_wr_en = fire, combinational. o_data_out = i_req_data[w] mux, combinational. Zero-cycle latency.
  - On fire: count+1.
  - If i_req_last[w], or count == MAX_BURST-1, then at the next edge: state IDLE, o_grant=0, rr pointer=(w+1) mod NUM_REQ.
  - Last and MAX_BURST on the same byte cause a single release.
  - Requester dropping valid mid-burst: grant is held, no rotation.
  - i_full=1: ready deasserts the same cycle, no write; resume when i_full falls.
- One IDLE cycle always separates consecutive bursts, even for the same requester.
- i_req_last/i_req_parity of non-granted requesters are ignored. i_req_parity[w] changes during XFER are ignored.
- o_parity_type never changes outside the DRAIN-to-XFER edge.
- Invariants:
  - o_grant is zero or one-hot.
  - o_wr_en implies exactly one ready bit is set.
  - o_wr_en is never 1 while i_full=1.
- Counter width is clog2(MAX_BURST). Count compare is done before increment.

Test Plan:
1. Reset mid-burst: assert rst_n=0 during an XFER → same cycle o_grant=0, o_wr_en=0; after release, IDLE with rr pointer 0.
2. Round-robin, single bursts:
   - Setup: requesters 0 and 2 each send 3 bytes (0xA0..0xA2, 0xC0..0xC2), last on the 3rd, same parity 00.
   - Required: FIFO writes A0 A1 A2 then C0 C1 C2; one idle cycle between bursts; grant 0001→0000→0100.
3. Parity switch:
   - Setup: req1 parity 01 while o_parity_type=00; hold i_tx_idle=0 for 20 cycles, then raise it.
   - Required: DRAIN for 20 cycles, no writes, o_parity_type=01 the cycle after i_tx_idle, then writes start.
4. Backpressure:
   - Setup: i_full=1 for 5 cycles mid-burst.
   - Required: o_wr_en=0 and o_req_ready=0 throughout; no byte lost or duplicated; order preserved.
5. Forced rotation:
   - Setup: MAX_BURST=4; req3 streams 10 bytes, never last; req0 also valid.
   - Required: 4 bytes from 3, then req0 burst, then 4 more from 3 (pointer wraps 3→0).
6. Simultaneous last and limit:
   - Setup: last on the 4th byte with MAX_BURST=4.
   - Required: single release, next grant goes to next requester, no extra IDLE cycle.
